// File: rtl/uart_match_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_match_ctrl_if
//   Signal bundle between the UART byte receiver / pattern matcher side and
//   the uart_match_ctrl command controller.
//
//   Handshake: rx_valid is a one-cycle strobe qualifying rx_data. There is no
//   ready/back-pressure path; the controller samples every strobe on the
//   cycle it is high. rx_frame_err is a one-cycle strobe that marks the frame
//   delivered in that same cycle as corrupt. match_in is a one-cycle pulse
//   per detected pattern. All controller outputs are registered.
//
//   Signals (direction seen from the controller, modport slave):
//     rx_data      in   8      received UART byte
//     rx_valid     in   1      byte strobe
//     rx_frame_err in   1      stop-bit error strobe
//     match_in     in   1      matcher hit pulse
//     pat_value    out  8      pattern value, bits >= pat_len are zero
//     pat_len      out  4      pattern length 1..8
//     matcher_en   out  1      matcher enable
//     matcher_clr  out  1      one-cycle matcher history flush
//     match_count  out  CNT_W  saturating hit counter
//     match_irq    out  1      sticky threshold interrupt
//     cmd_err      out  1      one-cycle rejected/aborted command pulse
//     busy         out  1      multi-byte command in progress
//     dbg_state    out  3      controller FSM state, for observation only
// ---------------------------------------------------------------------------
interface uart_match_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_frame_err;
  logic             match_in;
  logic [7:0]       pat_value;
  logic [3:0]       pat_len;
  logic             matcher_en;
  logic             matcher_clr;
  logic [CNT_W-1:0] match_count;
  logic             match_irq;
  logic             cmd_err;
  logic             busy;
  logic [2:0]       dbg_state;

  // Receiver/matcher side: drives bytes and hits, observes configuration.
  modport master (
    output rx_data, rx_valid, rx_frame_err, match_in,
    input  pat_value, pat_len, matcher_en, matcher_clr,
    input  match_count, match_irq, cmd_err, busy, dbg_state
  );

  // Controller side.
  modport slave (
    input  rx_data, rx_valid, rx_frame_err, match_in,
    output pat_value, pat_len, matcher_en, matcher_clr,
    output match_count, match_irq, cmd_err, busy, dbg_state
  );
endinterface

// File: rtl/uart_match_ctrl.sv
// ---------------------------------------------------------------------------
// uart_match_ctrl
//   Command-driven configuration and event controller for the UART
//   pattern-match datapath. Decodes command bytes from the UART receiver:
//     'E' (0x45)          enable matcher
//     'D' (0x44)          disable matcher
//     'C' (0x43)          clear hit counter and irq, flush matcher
//     'P' (0x50) len val  load pattern length (1..8) and value
//     'T' (0x54) thr      load irq threshold (0 disables the irq)
//   Counts matcher hits (saturating) and raises a sticky threshold irq.
//   Multi-byte commands abort on a frame error or on TIMEOUT_CYC cycles
//   without a byte.
//
//   Ports:
//     sys_clk  in   system clock
//     reset    in   asynchronous active-low reset
//     bus      slave modport of uart_match_ctrl_if (see that file)
// ---------------------------------------------------------------------------
module uart_match_ctrl #(
  parameter int         CNT_W       = 16,
  parameter logic [7:0] DEF_PATTERN = 8'h06,
  parameter int         DEF_LEN     = 4,
  parameter int         TIMEOUT_CYC = 25000
) (
  input  logic              sys_clk,
  input  logic              reset,
  uart_match_ctrl_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_T = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_LEN = 3'd1,
    S_GET_VAL = 3'd2,
    S_GET_THR = 3'd3,
    S_APPLY   = 3'd4
  } state_t;

  // Keeps only the low 'len' bits of a pattern value.
  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  localparam logic [3:0] RST_LEN   = 4'(DEF_LEN);
  localparam logic [7:0] RST_VALUE = DEF_PATTERN & len_mask(RST_LEN);

  state_t           r_state;
  logic [7:0]       r_pat_value;
  logic [3:0]       r_pat_len;
  logic [3:0]       r_len_lat;
  logic             r_en;
  logic             r_saved_en;
  logic             r_clr;
  logic             r_err;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_thr;
  logic             r_irq;
  logic [TMO_W-1:0] r_tmo;

  logic             w_in_get;
  logic             w_byte_ok;
  logic             w_tmo_hit;
  logic             w_cmd_clear;
  logic             w_count_ok;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_thr_nxt;
  logic             w_irq_nxt;
  logic             w_len_legal;

  always_comb begin
    w_in_get    = (r_state == S_GET_LEN) || (r_state == S_GET_VAL) ||
                  (r_state == S_GET_THR);
    // A byte that arrives with a frame error is never interpreted.
    w_byte_ok   = bus.rx_valid && !bus.rx_frame_err;
    w_tmo_hit   = w_in_get && !bus.rx_valid && (r_tmo == TMO_LAST);
    w_cmd_clear = (r_state == S_IDLE) && w_byte_ok && (bus.rx_data == CMD_C);
    w_len_legal = (bus.rx_data >= 8'd1) && (bus.rx_data <= 8'd8);

    // Enable is sampled before any command updates it, so a 'D' in the same
    // cycle as a hit still lets that hit count. Hits during APPLY are
    // dropped because the matcher history is being flushed then.
    w_count_ok  = bus.match_in && r_en && (r_state != S_APPLY);

    w_count_nxt = r_count;
    if (w_cmd_clear) begin
      w_count_nxt = '0;
    end else if (w_count_ok && (r_count != {CNT_W{1'b1}})) begin
      w_count_nxt = r_count + 1'b1;
    end

    w_thr_nxt = r_thr;
    if ((r_state == S_GET_THR) && w_byte_ok) begin
      w_thr_nxt = CNT_W'(bus.rx_data);
    end

    // Sticky: only a 'C' (or reset) drops the irq, raising the threshold
    // later does not.
    if (w_cmd_clear) begin
      w_irq_nxt = 1'b0;
    end else begin
      w_irq_nxt = r_irq || ((w_thr_nxt != '0) && (w_count_nxt >= w_thr_nxt));
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pat_value <= RST_VALUE;
      r_pat_len   <= RST_LEN;
      r_len_lat   <= RST_LEN;
      r_en        <= 1'b1;
      r_saved_en  <= 1'b1;
      r_clr       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_thr       <= '0;
      r_irq       <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_clr   <= 1'b0;
      r_err   <= 1'b0;
      r_count <= w_count_nxt;
      r_thr   <= w_thr_nxt;
      r_irq   <= w_irq_nxt;

      // Inter-byte timer: restarts whenever a byte arrives or no command is
      // open.
      if (!w_in_get || bus.rx_valid) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_byte_ok) begin
            unique case (bus.rx_data)
              CMD_E: r_en <= 1'b1;
              CMD_D: r_en <= 1'b0;
              CMD_C: r_clr <= 1'b1;
              CMD_P: begin
                // Matcher is held off while the pattern is being rewritten.
                r_saved_en <= r_en;
                r_en       <= 1'b0;
                r_state    <= S_GET_LEN;
                r_busy     <= 1'b1;
              end
              CMD_T: begin
                r_state <= S_GET_THR;
                r_busy  <= 1'b1;
              end
              default: r_err <= 1'b1;
            endcase
          end
        end

        S_GET_LEN: begin
          if (bus.rx_frame_err || w_tmo_hit) begin
            r_err   <= 1'b1;
            r_en    <= r_saved_en;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.rx_valid) begin
            if (w_len_legal) begin
              r_len_lat <= bus.rx_data[3:0];
              r_state   <= S_GET_VAL;
            end else begin
              r_err   <= 1'b1;
              r_en    <= r_saved_en;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        S_GET_VAL: begin
          if (bus.rx_frame_err || w_tmo_hit) begin
            r_err   <= 1'b1;
            r_en    <= r_saved_en;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.rx_valid) begin
            // Length and value switch together and are visible during the
            // APPLY cycle, alongside the flush pulse.
            r_pat_len   <= r_len_lat;
            r_pat_value <= bus.rx_data & len_mask(r_len_lat);
            r_clr       <= 1'b1;
            r_en        <= r_saved_en;
            r_state     <= S_APPLY;
          end
        end

        S_GET_THR: begin
          if (bus.rx_frame_err || w_tmo_hit) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.rx_valid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_APPLY: begin
          // Single cycle; a byte arriving here would be ignored, which the
          // UART byte spacing never allows.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pat_value   = r_pat_value;
  assign bus.pat_len     = r_pat_len;
  assign bus.matcher_en  = r_en;
  assign bus.matcher_clr = r_clr;
  assign bus.match_count = r_count;
  assign bus.match_irq   = r_irq;
  assign bus.cmd_err     = r_err;
  assign bus.busy        = r_busy;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_uart_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_match_ctrl
//   Directed bench for uart_match_ctrl. A command-level model (queue of
//   pending command bytes) predicts every output each cycle; literal checks
//   pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_uart_match_ctrl;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT_CYC = 25000;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  always #20 sys_clk = ~sys_clk;

  uart_match_ctrl_if #(.CNT_W(CNT_W)) bus();

  uart_match_ctrl #(
    .CNT_W(CNT_W),
    .DEF_PATTERN(8'h06),
    .DEF_LEN(4),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- bookkeeping ----------------
  int n_vec   = 0;
  int n_err   = 0;
  int n_print = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_print < 40) begin
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
      n_print++;
    end
  endtask

  // ---------------- command-level model ----------------
  logic             m_en    = 1'b1;
  logic             m_saved = 1'b1;
  logic             m_clr   = 1'b0;
  logic             m_err   = 1'b0;
  logic             m_irq   = 1'b0;
  logic             m_apply = 1'b0;
  logic [7:0]       m_val   = 8'h06;
  logic [3:0]       m_len   = 4'd4;
  logic [CNT_W-1:0] m_count = '0;
  logic [CNT_W-1:0] m_thr   = '0;
  logic [7:0]       pend[$];
  int               quiet   = 0;
  logic [11:0]      exp_q[$];

  function automatic logic [7:0] low_bits(input logic [7:0] v, input int n);
    int lim;
    lim = 1 << n;
    return 8'(int'(v) % lim);
  endfunction

  task automatic model_abort();
    m_err = 1'b1;
    if (pend[0] == 8'h50) m_en = m_saved;
    pend.delete();
  endtask

  always @(posedge sys_clk or negedge reset) begin
    logic       cur_apply;
    logic       cnt_ok;
    logic       do_clear;
    logic [7:0] len_byte;
    if (!reset) begin
      m_en = 1'b1; m_saved = 1'b1; m_clr = 1'b0; m_err = 1'b0;
      m_irq = 1'b0; m_apply = 1'b0; m_val = 8'h06; m_len = 4'd4;
      m_count = '0; m_thr = '0; quiet = 0;
      pend.delete();
      exp_q.delete();
    end else begin
      cur_apply = m_apply;
      m_apply   = 1'b0;
      m_clr     = 1'b0;
      m_err     = 1'b0;
      do_clear  = 1'b0;
      cnt_ok    = bus.match_in && m_en && !cur_apply;
      if (!cur_apply) begin
        if (pend.size() == 0) begin
          if (bus.rx_valid && !bus.rx_frame_err) begin
            case (bus.rx_data)
              8'h45: m_en = 1'b1;
              8'h44: m_en = 1'b0;
              8'h43: begin do_clear = 1'b1; m_clr = 1'b1; end
              8'h50: begin m_saved = m_en; m_en = 1'b0; pend.push_back(8'h50); quiet = 0; end
              8'h54: begin pend.push_back(8'h54); quiet = 0; end
              default: m_err = 1'b1;
            endcase
          end
        end else if (bus.rx_frame_err) begin
          model_abort();
        end else if (bus.rx_valid) begin
          pend.push_back(bus.rx_data);
          quiet = 0;
          if (pend[0] == 8'h54) begin
            m_thr = CNT_W'(bus.rx_data);
            pend.delete();
          end else if (pend.size() == 2) begin
            if (bus.rx_data < 8'd1 || bus.rx_data > 8'd8) begin
              m_err = 1'b1;
              m_en  = m_saved;
              pend.delete();
            end
          end else begin
            len_byte = pend[1];
            m_len    = len_byte[3:0];
            m_val    = low_bits(bus.rx_data, int'(len_byte));
            m_clr    = 1'b1;
            m_en     = m_saved;
            m_apply  = 1'b1;
            exp_q.push_back({m_len, m_val});
            pend.delete();
          end
        end else begin
          quiet++;
          if (quiet >= TIMEOUT_CYC) model_abort();
        end
      end
      if (do_clear) begin
        m_count = '0;
        m_irq   = 1'b0;
      end else if (cnt_ok && m_count != {CNT_W{1'b1}}) begin
        m_count = m_count + 1'b1;
      end
      if (m_thr != '0 && m_count >= m_thr) m_irq = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    logic [11:0] e;
    if (reset) begin
      check("pat_value",   32'(bus.pat_value),   32'(m_val));
      check("pat_len",     32'(bus.pat_len),     32'(m_len));
      check("matcher_en",  32'(bus.matcher_en),  32'(m_en));
      check("matcher_clr", 32'(bus.matcher_clr), 32'(m_clr));
      check("match_count", 32'(bus.match_count), 32'(m_count));
      check("match_irq",   32'(bus.match_irq),   32'(m_irq));
      check("cmd_err",     32'(bus.cmd_err),     32'(m_err));
      check("busy",        32'(bus.busy),        32'((pend.size() != 0) || m_apply));
      if (bus.matcher_clr && bus.busy) begin
        if (exp_q.size() == 0) begin
          check("apply_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("apply_cfg", 32'({bus.pat_len, bus.pat_value}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic ferr, input logic hit);
    @(negedge sys_clk);
    bus.rx_data      = b;
    bus.rx_valid     = 1'b1;
    bus.rx_frame_err = ferr;
    bus.match_in     = hit;
    @(negedge sys_clk);
    bus.rx_valid     = 1'b0;
    bus.rx_frame_err = 1'b0;
    bus.match_in     = 1'b0;
  endtask

  task automatic pulse_match(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      bus.match_in = 1'b1;
      @(negedge sys_clk);
      bus.match_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic load_pattern(input logic [7:0] len, input logic [7:0] val);
    send_byte(8'h50, 1'b0, 1'b0);
    send_byte(len, 1'b0, 1'b0);
    send_byte(val, 1'b0, 1'b0);
    idle(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int tmo_at;
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.rx_frame_err = 1'b0;
    bus.match_in     = 1'b0;

    idle(3);
    check("rst_pat_value", 32'(bus.pat_value), 32'h06);
    check("rst_pat_len",   32'(bus.pat_len),   32'd4);
    check("rst_en",        32'(bus.matcher_en), 32'd1);
    check("rst_count",     32'(bus.match_count), 32'd0);
    check("rst_irq",       32'(bus.match_irq), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_err",       32'(bus.cmd_err),   32'd0);
    reset = 1'b1;

    // Hits counted with default config.
    pulse_match(3);
    check("t1_count", 32'(bus.match_count), 32'd3);
    check("t1_pat",   32'(bus.pat_value),   32'h06);
    check("t1_len",   32'(bus.pat_len),     32'd4);
    check("t1_irq",   32'(bus.match_irq),   32'd0);

    // Pattern load P,3,5.
    send_byte(8'h50, 1'b0, 1'b0);
    check("p_en_off",  32'(bus.matcher_en), 32'd0);
    check("p_busy",    32'(bus.busy),       32'd1);
    send_byte(8'h03, 1'b0, 1'b0);
    check("p_en_off2", 32'(bus.matcher_en), 32'd0);
    send_byte(8'h05, 1'b0, 1'b0);
    check("apply_clr", 32'(bus.matcher_clr), 32'd1);
    check("apply_len", 32'(bus.pat_len),     32'd3);
    check("apply_val", 32'(bus.pat_value),   32'h05);
    check("apply_en",  32'(bus.matcher_en),  32'd1);
    idle(1);
    check("post_clr",  32'(bus.matcher_clr), 32'd0);
    check("post_busy", 32'(bus.busy),        32'd0);

    // Length boundaries and value masking.
    load_pattern(8'h04, 8'h16);
    check("mask4_val", 32'(bus.pat_value), 32'h06);
    load_pattern(8'h08, 8'hA5);
    check("len8_val",  32'(bus.pat_value), 32'hA5);
    check("len8_len",  32'(bus.pat_len),   32'd8);
    load_pattern(8'h01, 8'hFF);
    check("len1_val",  32'(bus.pat_value), 32'h01);
    load_pattern(8'h04, 8'h06);

    // Illegal lengths.
    send_byte(8'h50, 1'b0, 1'b0);
    send_byte(8'h09, 1'b0, 1'b0);
    check("len9_err", 32'(bus.cmd_err),    32'd1);
    check("len9_len", 32'(bus.pat_len),    32'd4);
    check("len9_val", 32'(bus.pat_value),  32'h06);
    check("len9_en",  32'(bus.matcher_en), 32'd1);
    send_byte(8'h50, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    check("len0_err", 32'(bus.cmd_err),    32'd1);

    // Inter-byte timeout after 'P'.
    send_byte(8'h50, 1'b0, 1'b0);
    tmo_at = 0;
    for (int i = 1; i <= TIMEOUT_CYC + 10 && tmo_at == 0; i++) begin
      @(negedge sys_clk);
      if (bus.cmd_err) tmo_at = i;
    end
    check("tmo_cycle", 32'(tmo_at), 32'(TIMEOUT_CYC));
    check("tmo_busy",  32'(bus.busy),       32'd0);
    check("tmo_en",    32'(bus.matcher_en), 32'd1);
    check("tmo_len",   32'(bus.pat_len),    32'd4);

    // Frame error on the length byte.
    send_byte(8'h50, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    check("ferr_err",  32'(bus.cmd_err),    32'd1);
    check("ferr_busy", 32'(bus.busy),       32'd0);
    check("ferr_en",   32'(bus.matcher_en), 32'd1);
    check("ferr_len",  32'(bus.pat_len),    32'd4);

    // Saved enable of 0 is what comes back after APPLY.
    send_byte(8'h44, 1'b0, 1'b0);
    load_pattern(8'h02, 8'h33);
    check("saved_en0", 32'(bus.matcher_en), 32'd0);
    check("len2_val",  32'(bus.pat_value),  32'h03);
    send_byte(8'h45, 1'b0, 1'b0);
    load_pattern(8'h04, 8'h06);

    // Threshold irq.
    send_byte(8'h43, 1'b0, 1'b0);
    check("clr_count", 32'(bus.match_count), 32'd0);
    send_byte(8'h54, 1'b0, 1'b0);
    check("thr_busy",  32'(bus.busy), 32'd1);
    send_byte(8'h02, 1'b0, 1'b0);
    pulse_match(1);
    check("irq_lo",    32'(bus.match_irq), 32'd0);
    pulse_match(1);
    check("irq_hi",    32'(bus.match_irq), 32'd1);
    send_byte(8'h54, 1'b0, 1'b0);
    send_byte(8'd100, 1'b0, 1'b0);
    check("irq_sticky", 32'(bus.match_irq), 32'd1);
    send_byte(8'h43, 1'b0, 1'b1);
    check("cm_count",  32'(bus.match_count), 32'd0);
    check("cm_irq",    32'(bus.match_irq),   32'd0);
    check("cm_clr",    32'(bus.matcher_clr), 32'd1);

    // Disable, coincident hit counts, later hits do not.
    send_byte(8'h44, 1'b0, 1'b1);
    check("dm_count",  32'(bus.match_count), 32'd1);
    check("dm_en",     32'(bus.matcher_en),  32'd0);
    pulse_match(5);
    check("dis_count", 32'(bus.match_count), 32'd1);
    send_byte(8'h45, 1'b1, 1'b0);
    check("idle_ferr_en",  32'(bus.matcher_en), 32'd0);
    check("idle_ferr_err", 32'(bus.cmd_err),    32'd0);
    send_byte(8'h7A, 1'b0, 1'b0);
    check("bad_cmd_err", 32'(bus.cmd_err), 32'd1);
    send_byte(8'h45, 1'b0, 1'b0);

    // Reset in the middle of a 'P' command.
    send_byte(8'h50, 1'b0, 1'b0);
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check("mr_en",    32'(bus.matcher_en),  32'd1);
    check("mr_busy",  32'(bus.busy),        32'd0);
    check("mr_count", 32'(bus.match_count), 32'd0);
    check("mr_err",   32'(bus.cmd_err),     32'd0);
    check("mr_len",   32'(bus.pat_len),     32'd4);
    check("mr_val",   32'(bus.pat_value),   32'h06);
    reset = 1'b1;
    pulse_match(1);
    check("mr_recount", 32'(bus.match_count), 32'd1);

    idle(2);
    check("apply_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_match_ctrl.md
Name: uart_match_ctrl

Overview:
- Command-driven configuration and event controller for the UART pattern-match datapath.
- Sits between the UART byte receiver and the serial pattern matcher.
- Decodes command bytes arriving over UART to load pattern value/length, enable/disable and clear the matcher.
- Counts matcher hits and raises a threshold interrupt.

Parameters:
- CNT_W, 16, width of match event counter
- DEF_PATTERN, 8'h06, pattern value after reset (4'b0110 in low bits)
- DEF_LEN, 4, pattern length after reset (legal 1..8)
- TIMEOUT_CYC, 25000, max cycles between command/argument bytes (1 ms at 25 MHz)

Ports:
- sys_clk  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received UART byte, valid only with rx_valid
- rx_valid  in  1  one-cycle strobe, new byte on rx_data
- rx_frame_err  in  1  one-cycle strobe, stop-bit error on current frame
- match_in  in  1  one-cycle pulse from matcher per detected pattern
- pat_value  out  8  pattern to matcher; bits at index >= pat_len forced 0
- pat_len  out  4  active pattern length 1..8
- matcher_en  out  1  matcher shift/compare enable
- matcher_clr  out  1  one-cycle pulse, flush matcher shift history
- match_count  out  CNT_W  saturating count of accepted matches
- match_irq  out  1  level, count >= threshold (threshold != 0)
- cmd_err  out  1  one-cycle pulse on any rejected/aborted command
- busy  out  1  high while a multi-byte command is in progress

Behaviour:
- Reset (reset=0, async) values:
  - pat_value = DEF_PATTERN masked to DEF_LEN, pat_len = DEF_LEN, matcher_en = 1.
  - matcher_clr = 0, match_count = 0, threshold = 0, match_irq = 0, cmd_err = 0, busy = 0, FSM = IDLE.
- All outputs registered; an effect appears on the cycle after the rx_valid cycle that triggers it.
- FSM states: IDLE, GET_LEN, GET_VAL, GET_THR, APPLY.
- IDLE, on rx_valid, decode rx_data:
  - 0x45 'E': matcher_en = 1.
  - 0x44 'D': matcher_en = 0.
  - 0x43 'C': match_count = 0, match_irq = 0, matcher_clr pulse.
  - 0x50 'P': save matcher_en, force matcher_en = 0, go to GET_LEN.
  - 0x54 'T': go to GET_THR.
  - Any other byte: cmd_err pulse, stay in IDLE.
- GET_LEN:
  - rx_data in 1..8: latch it, go to GET_VAL.
  - Otherwise: cmd_err, restore saved matcher_en, go to IDLE; old pattern unchanged.
- GET_VAL: latch rx_data, go to APPLY.
- APPLY (exactly one cycle):
  - pat_len/pat_value update atomically, matcher_clr = 1, matcher_en restored to saved value.
  - Return to IDLE.
- GET_THR: threshold = rx_data zero-extended to CNT_W, go to IDLE. Threshold 0 disables the irq.
- busy = 1 in GET_LEN, GET_VAL, GET_THR, APPLY.
- Abort conditions in any GET_* state:
  - rx_frame_err, or TIMEOUT_CYC cycles without rx_valid.
  - Response: cmd_err pulse, restore saved matcher_en (P only), IDLE, no config change.
  - Timeout counter restarts on each accepted byte.
- rx_frame_err in IDLE: the accompanying byte is ignored with no cmd_err.
- Match counting:
  - match_in is counted only while matcher_en = 1 and the FSM is not in APPLY.
  - Counter saturates at all ones, no wrap.
- match_irq:
  - Set when threshold != 0 and match_count >= threshold.
  - Cleared only by 'C' or reset; stays set if threshold is later raised.
  - match_irq = 1 is sticky.
- Simultaneous events:
  - 'C' and match_in in the same cycle: clear wins, count = 0.
  - 'D' and match_in in the same cycle: match counted (enable sampled before update).
- Reset mid-command: FSM returns to IDLE immediately, all registers take reset values, no cmd_err.

Test Plan:
- After reset, pulse match_in 3 times -> match_count = 3; pat_value = 0x06; pat_len = 4; match_irq = 0.
- Bytes 0x50, 0x03, 0x05 -> matcher_en low from after 0x50 until the APPLY cycle; then pat_len = 3, pat_value = 0x05, matcher_clr high exactly 1 cycle, matcher_en back to 1; busy low afterwards.
- Bytes 0x50, 0x09 -> cmd_err pulse, pat_len stays 4, pat_value stays 0x06, matcher_en = 1.
- Byte 0x50 then no byte for 25000 cycles -> cmd_err pulse, FSM IDLE, busy = 0, config unchanged. Repeat with rx_frame_err on the second byte -> same result.
- Bytes 0x54, 0x02; then 2 match_in pulses -> match_irq rises the cycle after the second pulse. Byte 0x43 sent coincident with a match_in -> match_count = 0, match_irq = 0.
- Byte 0x44, then 5 match_in pulses -> count unchanged. Byte 0x7A -> cmd_err. Reset (low) asserted mid 0x50 sequence -> all outputs at reset values.
